// File: rtl/sys_rst_pkg.sv
// Shared types and default sizing for the power-on / reset sequencer.
package sys_rst_pkg;

  typedef enum logic [2:0] {
    PWR_DLY,
    PLL_RST,
    PLL_WAIT,
    RELEASE,
    RUN,
    HOLD,
    FAULT
  } seq_state_e;

  localparam int RETRY_W = 2;

  localparam int DEF_NUM_DOM       = 4;
  localparam int DEF_SYS_DELAY_TOP = 2500000;
  localparam int DEF_PLL_RST_CYC   = 64;
  localparam int DEF_LOCK_FILT     = 16;
  localparam int DEF_LOCK_TO       = 500000;
  localparam int DEF_STAGGER       = 256;
  localparam int DEF_MAX_RETRY     = 3;
  localparam int DEF_CNT_W         = 24;

endpackage

// File: rtl/lock_sync_filt.sv
// PLL lock 2-flop synchroniser plus consecutive-high filter; lock_ok is asserted on
// the cycle the LOCK_FILT-th consecutive synchronised high is seen while filt_en is set.
module lock_sync_filt
  import sys_rst_pkg::*;
#(
  parameter int LOCK_FILT = DEF_LOCK_FILT
) (
  input  logic clk,
  input  logic rst,
  input  logic filt_en,
  input  logic pll_locked,
  output logic lock_s,
  output logic lock_ok
);
  localparam int FW = $clog2(LOCK_FILT + 1);
  localparam logic [FW-1:0] FILT_TOP  = FW'(LOCK_FILT);
  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILT - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [FW-1:0] filt_q, filt_d;

  always_comb begin
    sync1_d = pll_locked;
    sync2_d = sync1_q;
    filt_d  = '0;
    // Any low sample, or leaving the wait state, restarts the run length.
    if (filt_en && sync2_q) begin
      filt_d = (filt_q == FILT_TOP) ? filt_q : filt_q + FW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
    end
  end

  assign lock_s  = sync2_q;
  assign lock_ok = filt_en && sync2_q && (filt_q >= FILT_LAST);

endmodule

// File: rtl/sys_rst_seq.sv
// Power-on/reset sequencer: PLL reset hold, lock qualification, staggered domain release.
// All outputs registered; lock adds 2 sync clocks; no backpressure (free-running control).
module sys_rst_seq
  import sys_rst_pkg::*;
#(
  parameter int NUM_DOM       = DEF_NUM_DOM,
  parameter int SYS_DELAY_TOP = DEF_SYS_DELAY_TOP,
  parameter int PLL_RST_CYC   = DEF_PLL_RST_CYC,
  parameter int LOCK_FILT     = DEF_LOCK_FILT,
  parameter int LOCK_TO       = DEF_LOCK_TO,
  parameter int STAGGER       = DEF_STAGGER,
  parameter int MAX_RETRY     = DEF_MAX_RETRY,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic               clk_50m,
  input  logic               rst,
  input  logic               ext_rst_req,
  input  logic               pll_locked,
  output logic               pll_rst,
  output logic [NUM_DOM-1:0] dom_rst_n,
  output logic               seq_done,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_cnt
);
  localparam int SW = $clog2(STAGGER + 1);
  localparam int IW = $clog2(NUM_DOM + 1);
  localparam logic [CNT_W-1:0]   DLY_LAST  = CNT_W'(SYS_DELAY_TOP - 1);
  localparam logic [CNT_W-1:0]   PRST_LAST = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(LOCK_TO - 1);
  localparam logic [SW-1:0]      STG_LAST  = SW'(STAGGER - 1);
  localparam logic [IW-1:0]      DOM_LAST  = IW'(NUM_DOM - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]      stg_q, stg_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
  logic [NUM_DOM-1:0] dom_rst_n_q, dom_rst_n_d;
  logic               pll_rst_q, pll_rst_d;
  logic               seq_done_q, seq_done_d;
  logic               fault_q, fault_d;
  logic               filt_en, lock_s, lock_ok;

  assign filt_en = (state_q == PLL_WAIT);

  lock_sync_filt #(.LOCK_FILT(LOCK_FILT)) u_lock (
    .clk        (clk_50m),
    .rst        (rst),
    .filt_en    (filt_en),
    .pll_locked (pll_locked),
    .lock_s     (lock_s),
    .lock_ok    (lock_ok)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stg_d       = stg_q;
    idx_d       = idx_q;
    retry_cnt_d = retry_cnt_q;
    dom_rst_n_d = dom_rst_n_q;

    unique case (state_q)
      PWR_DLY: if (cnt_q == DLY_LAST) state_d = PLL_WAIT; else cnt_d = cnt_q + CNT_W'(1);
      PLL_RST: if (cnt_q == PRST_LAST) state_d = PLL_WAIT; else cnt_d = cnt_q + CNT_W'(1);
      PLL_WAIT: begin
        if (lock_ok) begin
          state_d = RELEASE;
        end else if (cnt_q == TO_LAST) begin
          if (retry_cnt_q < RETRY_MAX) begin
            retry_cnt_d = retry_cnt_q + RETRY_W'(1);
            state_d     = PLL_RST;
          end else begin
            state_d = FAULT;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          state_d = PLL_RST;
        end else if (ext_rst_req) begin
          state_d = HOLD;
        end else if (stg_q == STG_LAST) begin
          dom_rst_n_d = dom_rst_n_q | (NUM_DOM'(1) << idx_q);
          idx_d       = idx_q + IW'(1);
          stg_d       = '0;
          if (idx_q == DOM_LAST) state_d = RUN;
        end else begin
          stg_d = stg_q + SW'(1);
        end
      end
      RUN: begin
        if (!lock_s) state_d = PLL_RST;
        else if (ext_rst_req) state_d = HOLD;
      end
      HOLD: begin
        // Tail timer only runs once the request has dropped; a re-assert restarts it.
        if (!lock_s) state_d = PLL_RST;
        else if (ext_rst_req) stg_d = '0;
        else if (stg_q == STG_LAST) state_d = RELEASE;
        else stg_d = stg_q + SW'(1);
      end
      FAULT: state_d = FAULT;
      default: state_d = PWR_DLY;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
      stg_d = '0;
      if (state_d == RELEASE) begin
        dom_rst_n_d = NUM_DOM'(1);
        idx_d       = IW'(1);
        if (NUM_DOM == 1) state_d = RUN;
      end
    end

    if (state_d == RUN) dom_rst_n_d = '1;
    else if (state_d != RELEASE) dom_rst_n_d = '0;

    pll_rst_d  = state_d inside {PWR_DLY, PLL_RST, FAULT};
    seq_done_d = (state_d == RUN);
    fault_d    = (state_d == FAULT);
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q     <= PWR_DLY;
      cnt_q       <= '0;
      stg_q       <= '0;
      idx_q       <= '0;
      retry_cnt_q <= '0;
      dom_rst_n_q <= '0;
      pll_rst_q   <= 1'b1;
      seq_done_q  <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stg_q       <= stg_d;
      idx_q       <= idx_d;
      retry_cnt_q <= retry_cnt_d;
      dom_rst_n_q <= dom_rst_n_d;
      pll_rst_q   <= pll_rst_d;
      seq_done_q  <= seq_done_d;
      fault_q     <= fault_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign dom_rst_n = dom_rst_n_q;
  assign seq_done  = seq_done_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_cnt_q;

endmodule

// File: tb/tb_sys_rst_seq.sv
// Bench for sys_rst_seq: directed scenarios plus random lock/request traffic, every
// cycle compared against a timestamp-based model of the sequencing rules.
module tb_sys_rst_seq;
  localparam int NUM_DOM       = 3;
  localparam int SYS_DELAY_TOP = 20;
  localparam int PLL_RST_CYC   = 5;
  localparam int LOCK_FILT     = 3;
  localparam int LOCK_TO       = 50;
  localparam int STAGGER       = 4;
  localparam int MAX_RETRY     = 2;
  localparam int CNT_W         = 24;

  localparam int P_PWR = 0, P_PRST = 1, P_WAIT = 2, P_REL = 3, P_RUN = 4, P_HOLD = 5, P_FAULT = 6;

  logic               clk_50m = 1'b0;
  logic               rst = 1'b1;
  logic               ext_rst_req = 1'b0;
  logic               pll_locked = 1'b0;
  logic               pll_rst, seq_done, fault;
  logic [NUM_DOM-1:0] dom_rst_n;
  logic [1:0]         retry_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: current phase, edge index of phase entry, lock run length.
  int   n = 0, ph = P_PWR, t0 = 0, t_low = -1, run_len = 0, retries = 0;
  logic lk1 = 1'b0, lk2 = 1'b0;

  sys_rst_seq #(
    .NUM_DOM(NUM_DOM), .SYS_DELAY_TOP(SYS_DELAY_TOP), .PLL_RST_CYC(PLL_RST_CYC),
    .LOCK_FILT(LOCK_FILT), .LOCK_TO(LOCK_TO), .STAGGER(STAGGER),
    .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)
  ) dut (
    .clk_50m     (clk_50m),
    .rst         (rst),
    .ext_rst_req (ext_rst_req),
    .pll_locked  (pll_locked),
    .pll_rst     (pll_rst),
    .dom_rst_n   (dom_rst_n),
    .seq_done    (seq_done),
    .fault       (fault),
    .retry_cnt   (retry_cnt)
  );

  always #10 clk_50m = ~clk_50m;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {fault, seq_done, retry_cnt, pll_rst, dom_rst_n};
  endfunction

  function automatic logic [7:0] expected_outs();
    int k;
    logic [NUM_DOM-1:0] dm;
    dm = '0;
    if (ph == P_RUN) begin
      dm = '1;
    end else if (ph == P_REL) begin
      k = (n - t0) / STAGGER + 1;
      if (k > NUM_DOM) k = NUM_DOM;
      dm = NUM_DOM'((1 << k) - 1);
    end
    return {(ph == P_FAULT), (ph == P_RUN), 2'(retries),
            (ph == P_PWR || ph == P_PRST || ph == P_FAULT), dm};
  endfunction

  task automatic enter(input int p);
    ph = p; t0 = n; run_len = 0; t_low = -1;
  endtask

  // One clock: the model consumes the inputs sampled on this edge, then outputs are compared.
  task automatic step();
    logic ls;
    @(posedge clk_50m);
    n++;
    ls  = lk2;
    lk2 = rst ? 1'b0 : lk1;
    lk1 = rst ? 1'b0 : pll_locked;
    if (rst) begin
      retries = 0;
      enter(P_PWR);
    end else begin
      case (ph)
        P_PWR:  if (n - t0 == SYS_DELAY_TOP) enter(P_WAIT);
        P_PRST: if (n - t0 == PLL_RST_CYC) enter(P_WAIT);
        P_WAIT: begin
          run_len = ls ? run_len + 1 : 0;
          if (run_len == LOCK_FILT) enter(P_REL);
          else if (n - t0 == LOCK_TO) begin
            if (retries < MAX_RETRY) begin retries++; enter(P_PRST); end
            else enter(P_FAULT);
          end
        end
        P_REL, P_RUN, P_HOLD: begin
          if (!ls) enter(P_PRST);
          else if (ph != P_HOLD && ext_rst_req) enter(P_HOLD);
          else if (ph == P_REL && n - t0 == (NUM_DOM - 1) * STAGGER) enter(P_RUN);
          else if (ph == P_HOLD) begin
            if (ext_rst_req) t_low = -1;
            else begin
              if (t_low < 0) t_low = n;
              if (n - t_low + 1 == STAGGER) enter(P_REL);
            end
          end
        end
        default: ;
      endcase
    end
    #1;
    check_eq($sformatf("outs@%0d", n), 32'(outs()), 32'(expected_outs()));
  endtask

  // Step until (outs & mask) == val or the budget runs out; k is the number of steps taken.
  task automatic run_until(input logic [7:0] mask, input logic [7:0] val, input int budget,
                           output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (((outs() & mask) != val) && k < budget);
  endtask

  initial begin
    int k, len;

    // Power-on with lock arriving 10 clocks after the PLL is released.
    rst = 1'b1; step(); step(); rst = 1'b0;
    run_until(8'h08, 8'h00, 200, k); check_eq("pwr_dly_len", k, SYS_DELAY_TOP);
    repeat (10) step();
    pll_locked = 1'b1;
    run_until(8'h01, 8'h01, 100, k); check_eq("lock_accept", k, 2 + LOCK_FILT);
    run_until(8'h40, 8'h40, 100, k); check_eq("stagger_done", k, (NUM_DOM - 1) * STAGGER);

    // Lock loss in RUN: reset within 3 clocks, PLL pulse, full re-release.
    repeat (3) step();
    pll_locked = 1'b0;
    run_until(8'h07, 8'h00, 20, k); check_eq("loss_react", k, 3);
    step(); pll_locked = 1'b1;
    run_until(8'h40, 8'h40, 200, k);
    check_eq("rerelease_done", seq_done, 1);
    check_eq("retry_after_loss", retry_cnt, 0);

    // External reset requests of random length.
    for (int r = 0; r < 3; r++) begin
      len = $urandom_range(1, 8);
      ext_rst_req = 1'b1; step();
      check_eq("ext_react", dom_rst_n, 0);
      repeat (len - 1) step();
      ext_rst_req = 1'b0;
      run_until(8'h01, 8'h01, 50, k); check_eq("hold_tail", k, STAGGER);
      run_until(8'h40, 8'h40, 50, k); check_eq("ext_rerun", k, (NUM_DOM - 1) * STAGGER);
      repeat ($urandom_range(0, 5)) step();
    end

    // One-clock lock glitch while the filter is counting.
    pll_locked = 1'b0; rst = 1'b1; step(); rst = 1'b0;
    run_until(8'h08, 8'h00, 200, k);
    pll_locked = 1'b1;
    repeat ($urandom_range(0, 2)) step();
    pll_locked = 1'b0; step(); pll_locked = 1'b1;
    run_until(8'h01, 8'h01, 100, k); check_eq("glitch_accept", k, 2 + LOCK_FILT);

    // rst in the middle of the staggered release.
    run_until(8'h07, 8'h03, 50, k); check_eq("mid_rel_reach", dom_rst_n, 3'b011);
    rst = 1'b1; step();
    check_eq("rst_pll", pll_rst, 1);
    check_eq("rst_dom", dom_rst_n, 0);
    check_eq("rst_done", seq_done, 0);
    rst = 1'b0;
    run_until(8'h08, 8'h00, 200, k); check_eq("pwr_dly_repeat", k, SYS_DELAY_TOP);

    // Lock never asserts: two retries then the fault state, which is sticky.
    pll_locked = 1'b0; rst = 1'b1; step(); rst = 1'b0;
    run_until(8'h80, 8'h80, 400, k);
    check_eq("fault_set", fault, 1);
    check_eq("fault_retry", retry_cnt, MAX_RETRY);
    check_eq("fault_time", k, SYS_DELAY_TOP + (MAX_RETRY + 1) * LOCK_TO + MAX_RETRY * PLL_RST_CYC);
    pll_locked = 1'b1; ext_rst_req = 1'b1;
    repeat (20) step();
    ext_rst_req = 1'b0;
    check_eq("fault_sticky", fault, 1);

    // Random lock/request traffic with occasional rst.
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      if (pll_locked) begin
        if ($urandom_range(0, 79) == 0) pll_locked = 1'b0;
      end else if ($urandom_range(0, 5) == 0) begin
        pll_locked = 1'b1;
      end
      if (ext_rst_req) begin
        if ($urandom_range(0, 2) == 0) ext_rst_req = 1'b0;
      end else if ($urandom_range(0, 39) == 0) begin
        ext_rst_req = 1'b1;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sys_rst_seq.md
# sys_rst_seq

Parametrised power-on and reset sequencer that succeeds the single-PLL system index block. Sits at the top of the design between the board clock/PLL and all functional logic. Holds the PLL in reset for a power-on delay, qualifies PLL lock, releases `NUM_DOM` reset domains in a staggered order, and re-sequences on lock loss or an external reset request. It also has bounded lock retries and a fault state.

## Interface
- `NUM_DOM`, 4: number of reset domains; domain 0 is released first.
- `SYS_DELAY_TOP`, 2500000: power-on delay in clocks (50 ms at 50 MHz).
- `PLL_RST_CYC`, 64: `pll_rst` hold length on every retry or re-sequence.
- `LOCK_FILT`, 16: consecutive synchronised-high lock cycles needed to accept lock.
- `LOCK_TO`, 500000: clocks allowed for lock after `pll_rst` release.
- `STAGGER`, 256: clocks between successive domain releases; ≥1.
- `MAX_RETRY`, 3: lock timeouts tolerated before the fault state.
- `CNT_W`, 24: delay/timeout counter width; must hold max(`SYS_DELAY_TOP`, `LOCK_TO`).
- `clk_50m`  in  1  free-running board clock; the only clock.
- `rst`  in  1  synchronous active-high reset; restarts the full power-on sequence.
- `ext_rst_req`  in  1  synchronous request to re-reset all domains without the PLL cycle.
- `pll_locked`  in  1  asynchronous PLL lock; synchronised internally with 2 flops.
- `pll_rst`  out  1  PLL reset, active high.
- `dom_rst_n`  out  `NUM_DOM`  per-domain reset, active low, registered.
- `seq_done`  out  1  high while all domains are released.
- `fault`  out  1  lock retries exhausted.
- `retry_cnt`  out  2  lock timeouts since `rst`; saturates at 3.

## Operation
- Reset values (`rst`=1 at a clock edge):
  - `pll_rst`=1, `dom_rst_n`=0, `seq_done`=0, `fault`=0, `retry_cnt`=0.
  - State `PWR_DLY`, counters 0, synchroniser and filter cleared.
- **PWR_DLY**: count `SYS_DELAY_TOP` clocks with `pll_rst`=1, then go to `PLL_WAIT`. `ext_rst_req` is ignored.
- **PLL_RST**: hold `pll_rst`=1 for `PLL_RST_CYC` clocks, then go to `PLL_WAIT`.
- **PLL_WAIT**: `pll_rst`=0, timeout counter runs, filter counts consecutive synchronised-lock highs.
  - Filter reaches `LOCK_FILT`: go to `RELEASE`.
  - Timeout reaches `LOCK_TO` first, and `retry_cnt` < `MAX_RETRY`: `retry_cnt`++, go to `PLL_RST`.
  - Timeout reaches `LOCK_TO` first, otherwise: go to `FAULT`.
  - Any low lock sample restarts the filter.
- **RELEASE**: `dom_rst_n[k]` rises `k`*`STAGGER` clocks after entry. Released bits stay high.
- **RUN**: entered on the same edge the last domain is released. `seq_done`=1.
- **HOLD**: all `dom_rst_n`=0 while `ext_rst_req`=1, plus `STAGGER` clocks after it falls, then `RELEASE`. `pll_rst` stays 0.
- **FAULT**: `pll_rst`=1, all domains in reset, `fault`=1. Exits only on `rst`.
- Lock loss: synchronised lock low in `RELEASE`, `RUN` or `HOLD` → all `dom_rst_n`=0 and `seq_done`=0 on the next edge, then `PLL_RST`. Does not increment `retry_cnt`.
- `ext_rst_req` in `RELEASE` or `RUN` → `HOLD`.
- Simultaneous events: lock loss takes priority over `ext_rst_req`.
- `rst` mid-sequence from any state returns all outputs to their reset values on that edge.
- Domain release order is strictly ascending index. No domain is released while a lower-index domain is in reset.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- After `rst` falls, `pll_rst` falls on clock `SYS_DELAY_TOP`.
- Lock acceptance latency is 2 (sync) + `LOCK_FILT` clocks after `pll_locked` rises stably.
- Lock-loss reaction is 2 sync clocks + 1 register clock = 3 clocks from the `pll_locked` fall to `dom_rst_n`=0.
- `ext_rst_req` reaction: `dom_rst_n`=0 one clock after sampled high.
- `seq_done` rises on the same edge as `dom_rst_n[NUM_DOM-1]`, (`NUM_DOM`-1)*`STAGGER` clocks after `RELEASE` entry.
- Counters are unsigned `CNT_W` bits, cleared on every state entry, and never wrap (compare-equal terminal).

## Structure
- Package `sys_rst_pkg`:
  - state enum `PWR_DLY`, `PLL_RST`, `PLL_WAIT`, `RELEASE`, `RUN`, `HOLD`, `FAULT`.
  - default parameter constants.
  - `retry_cnt` width constant.
- Sub-module `lock_sync_filt`: 2-flop synchroniser plus `LOCK_FILT` consecutive-high counter. Outputs `lock_s` (synchronised) and `lock_ok` (filtered).
- Top: FSM, shared delay/timeout counter, stagger counter with domain index, output registers.

## Test plan
Parameters: `SYS_DELAY_TOP`=20, `PLL_RST_CYC`=5, `LOCK_FILT`=3, `LOCK_TO`=50, `STAGGER`=4, `NUM_DOM`=3, `MAX_RETRY`=2.
- Power-on, lock high 10 clocks after `pll_rst` falls:
  - `pll_rst` falls at clock 20.
  - `dom_rst_n` goes 001→011→111 at 4-clock spacing; `seq_done`=1 with the last step.
- Lock never asserts:
  - `retry_cnt` steps 1, 2, with a 5-clock `pll_rst` pulse before each retry.
  - Third timeout → `fault`=1, `pll_rst`=1, `dom_rst_n`=000.
- Lock glitch low for 1 clock during `PLL_WAIT` filter → filter restarts; release delayed by the filter restart.
- Lock drops in `RUN` → `dom_rst_n`=000 3 clocks later, 5-clock `pll_rst` pulse, full re-release; `retry_cnt` unchanged.
- `ext_rst_req` high 6 clocks in `RUN` → `dom_rst_n`=000 next clock, `pll_rst` stays 0; 4 clocks after the request falls, staggered release restarts.
- `rst` asserted mid-`RELEASE` with `dom_rst_n`=011 → next edge all outputs at reset values; full 20-clock delay repeats.
